fpro_key_poller: RTL and testbench
==================================

Name: fpro_key_poller

Overview:
- Avalon-MM read initiator that periodically polls a memory-mapped key PIO responder at a fixed address.
- Debounces the returned key bits and reports the stable key state, one-cycle press/release pulses and sticky press flags with an interrupt.
- Sits between the key PIO's s1 port and FPRO logic that needs clean key events without software polling.

Parameters:
- DATA_W, 2, number of key bits taken from readdata[DATA_W-1:0]
- POLL_DIV, 50000, clock cycles between poll launches (>=4)
- DEB_CNT, 4, consecutive identical samples required before a change is accepted (1..15)
- KEY_ADDR, 2'b00, Avalon word address of the PIO data register
- ACTIVE_LOW, 1, 1 = raw key bit 0 means pressed

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- avm_address  out  2  Avalon address, constant KEY_ADDR
- avm_read  out  1  read request
- avm_waitrequest  in  1  responder stall
- avm_readdata  in  32  responder read data, valid exactly 1 cycle after the accepted read (fixed latency 1)
- keys_stable  out  DATA_W  debounced state, 1 = pressed
- press_pulse  out  DATA_W  1-cycle pulse per newly pressed key
- release_pulse  out  DATA_W  1-cycle pulse per newly released key
- press_flags  out  DATA_W  sticky press record
- flag_clr  in  DATA_W  per-bit clear of press_flags
- irq  out  1  OR of press_flags
- overrun  out  1  sticky; poll tick arrived while a transaction was in flight (cleared only by reset)

Behaviour:
- Reset values:
  - avm_read=0; keys_stable, press_pulse, release_pulse, press_flags, irq and overrun all 0.
  - State IDLE; timer=POLL_DIV-1; last_sample=0; match_cnt=0.
- Timer: free-running down-counter. At 0 it emits tick and reloads POLL_DIV-1, so ticks occur every POLL_DIV cycles.
- FSM:
  - IDLE: on tick, go to REQ.
  - REQ: avm_read=1. The read is accepted in the cycle avm_waitrequest=0; then go to DATA. avm_read and address stay stable while waitrequest=1 (no timeout).
  - DATA: capture sample = avm_readdata[DATA_W-1:0], inverted if ACTIVE_LOW; go to EVAL.
  - EVAL: debounce update, then return to IDLE.
- Tick outside IDLE: the tick is dropped and overrun is set. The transaction in flight completes normally.
- Debounce (EVAL):
  - If sample == last_sample, match_cnt saturates upward at DEB_CNT. Otherwise last_sample<=sample and match_cnt<=1.
  - When the post-update match_cnt == DEB_CNT and sample != keys_stable:
    - keys_stable<=sample
    - press_pulse<=sample & ~keys_stable
    - release_pulse<=~sample & keys_stable
  - press_pulse and release_pulse are otherwise 0; each pulse lasts exactly one cycle (the cycle after EVAL).
  - With DEB_CNT=1, every sample that differs from keys_stable is accepted.
- press_flags:
  - Next value = (press_flags & ~flag_clr) | press_pulse. Set wins on a simultaneous set and clear of the same bit.
  - irq = |press_flags, registered, so it follows the flags by one cycle.
- Latency from the accepted read to keys_stable changing: 2 cycles (DATA, EVAL).
- Reset mid-transaction: avm_read drops on the next edge. Any readdata that arrives afterwards is ignored because the FSM is in IDLE.
- Upper readdata bits are ignored.

Decomposition:
- Shared package fpro_key_pkg:
  - FSM state enum (IDLE, REQ, DATA, EVAL)
  - DEB_W = $clog2(DEB_CNT+1)
  - timer width constant derived from POLL_DIV
- One natural sub-module, fpro_key_debounce: holds last_sample, match_cnt, keys_stable and the pulse generation, with a sample_valid strobe input. The poll FSM and the Avalon logic stay in the top module.

Test Plan:
(Bench parameters: POLL_DIV=8, DEB_CNT=3, ACTIVE_LOW=1, responder model with latency 1.)
- Reset release, readdata=32'h3 (released), no waitrequest -> avm_read pulses 1 cycle every 8 cycles at avm_address=0; keys_stable stays 2'b00; irq=0.
- Readdata=32'h2 for 3 consecutive polls -> after the 3rd EVAL, keys_stable=2'b01, press_pulse=2'b01 for exactly 1 cycle, press_flags=2'b01, irq=1 one cycle later.
- Bounce pattern 2,3,2,2,2 -> no change until the 3rd consecutive 2, then the same result as above; no release_pulse at any point.
- waitrequest held high 12 cycles during REQ -> avm_read stays 1 with stable address, overrun=1, exactly one accepted read.
- flag_clr=2'b01 asserted in the same cycle as a press_pulse on bit 0 -> press_flags[0] stays 1; a later lone clear -> press_flags=0 and irq=0 the next cycle.
- Reset asserted while in REQ with waitrequest=1 -> avm_read=0 next cycle; all outputs 0; polling resumes 8 cycles after reset is released.

Source files
------------

// File: rtl/fpro_key_poller_pkg.sv
// Shared types and width helpers for the key poller.
// Widths are derived per instance from its parameters.
package fpro_key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    EVAL
  } poll_state_e;

  localparam int POLL_DIV_DEF = 50000;
  localparam int DEB_CNT_DEF  = 4;

  localparam int DEB_W = $clog2(DEB_CNT_DEF + 1);
  localparam int TMR_W = $clog2(POLL_DIV_DEF);

  function automatic int deb_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int tmr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fpro_key_poller_if.sv
// Avalon-MM read bus between the poller and the key PIO.
// Address/read flow initiator->responder; stall/data flow back.
interface fpro_key_poller_if #(
  parameter int AW = 2,
  parameter int DW = 32
);

  logic [AW-1:0] address;
  logic          read;
  logic          waitrequest;
  logic [DW-1:0] readdata;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdata
  );

endinterface

// File: rtl/fpro_key_poller_debounce.sv
// Sample-count debouncer with press/release edge pulses.
// Updates only on sample_valid_i; pulses last one cycle.
module fpro_key_debounce
  import fpro_key_pkg::*;
#(
  parameter int DATA_W  = 2,
  parameter int DEB_CNT = DEB_CNT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic [DATA_W-1:0] keys_stable_o,
  output logic [DATA_W-1:0] press_pulse_o,
  output logic [DATA_W-1:0] release_pulse_o
);

  localparam int DW = deb_w(DEB_CNT);
  localparam logic [DW-1:0] CNT_MAX = DW'(DEB_CNT);

  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] stable_q, stable_d;
  logic [DATA_W-1:0] press_q, press_d;
  logic [DATA_W-1:0] rel_q, rel_d;
  logic [DW-1:0]     cnt_q, cnt_d;

  always_comb begin
    last_d   = last_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = '0;
    rel_d    = '0;
    if (sample_valid_i) begin
      if (sample_i == last_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + DW'(1);
      end else begin
        last_d = sample_i;
        cnt_d  = DW'(1);
      end
      // Accept only once the run length reaches the threshold
      if (cnt_d == CNT_MAX && sample_i != stable_q) begin
        stable_d = sample_i;
        press_d  = sample_i & ~stable_q;
        rel_d    = ~sample_i & stable_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      press_q  <= '0;
      rel_q    <= '0;
    end else begin
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign keys_stable_o   = stable_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = rel_q;

endmodule

// File: rtl/fpro_key_poller.sv
// Periodic Avalon-MM poller of a key PIO with debounce,
// edge pulses, sticky press flags, irq and overrun status.
module fpro_key_poller
  import fpro_key_pkg::*;
#(
  parameter int         DATA_W     = 2,
  parameter int         POLL_DIV   = POLL_DIV_DEF,
  parameter int         DEB_CNT    = DEB_CNT_DEF,
  parameter logic [1:0] KEY_ADDR   = 2'b00,
  parameter bit         ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  fpro_key_poller_if.master   avm,
  output logic [DATA_W-1:0]   keys_stable,
  output logic [DATA_W-1:0]   press_pulse,
  output logic [DATA_W-1:0]   release_pulse,
  output logic [DATA_W-1:0]   press_flags,
  input  logic [DATA_W-1:0]   flag_clr,
  output logic                irq,
  output logic                overrun
);

  localparam int TW = tmr_w(POLL_DIV);
  localparam logic [TW-1:0] RELOAD = TW'(POLL_DIV - 1);

  logic [TW-1:0]     timer_q, timer_d;
  logic              tick;
  poll_state_e       state_q;
  logic              read_q;
  logic              overrun_q;
  logic [DATA_W-1:0] sample_q;
  logic [DATA_W-1:0] sample_w;
  logic [DATA_W-1:0] rd_key_w;
  logic [DATA_W-1:0] flags_q, flags_d;
  logic              irq_q;
  logic              unused_rd_w;

  always_comb begin
    tick    = (timer_q == '0);
    timer_d = tick ? RELOAD : timer_q - TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) timer_q <= RELOAD;
    else       timer_q <= timer_d;
  end

  assign rd_key_w    = avm.readdata[DATA_W-1:0];
  assign sample_w    = ACTIVE_LOW ? ~rd_key_w : rd_key_w;
  assign unused_rd_w = ^avm.readdata[31:DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      read_q    <= 1'b0;
      sample_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      // A tick while busy is dropped; the bus cycle still finishes
      if (tick && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= REQ;
            read_q  <= 1'b1;
          end
        end
        REQ: begin
          if (!avm.waitrequest) begin
            state_q <= DATA;
            read_q  <= 1'b0;
          end
        end
        DATA: begin
          sample_q <= sample_w;
          state_q  <= EVAL;
        end
        EVAL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  fpro_key_debounce #(
    .DATA_W  (DATA_W),
    .DEB_CNT (DEB_CNT)
  ) u_deb (
    .clk             (clk),
    .reset           (reset),
    .sample_valid_i  (state_q == EVAL),
    .sample_i        (sample_q),
    .keys_stable_o   (keys_stable),
    .press_pulse_o   (press_pulse),
    .release_pulse_o (release_pulse)
  );

  assign flags_d = (flags_q & ~flag_clr) | press_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      irq_q   <= |flags_q;
    end
  end

  assign avm.address = KEY_ADDR;
  assign avm.read    = read_q;
  assign press_flags = flags_q;
  assign irq         = irq_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fpro_key_poller.sv
// Directed plus randomized bench for fpro_key_poller with a
// latency-1 responder and a history-based debounce model.
module tb_fpro_key_poller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] flag_clr = 2'b00;
  logic [1:0] keys_stable, press_pulse, release_pulse, press_flags;
  logic       irq, overrun;

  fpro_key_poller_if avm ();

  fpro_key_poller #(
    .DATA_W     (2),
    .POLL_DIV   (8),
    .DEB_CNT    (3),
    .KEY_ADDR   (2'b00),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avm           (avm),
    .keys_stable   (keys_stable),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_flags   (press_flags),
    .flag_clr      (flag_clr),
    .irq           (irq),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_rise = -1;

  logic [1:0]  raw = 2'b11;
  logic [1:0]  hist[$];
  logic [1:0]  m_s, m_stable = 2'b00, m_press = 2'b00, m_rel = 2'b00;
  logic [1:0]  m_flags = 2'b00;
  logic [31:0] rd;
  bit          acc;

  // Responder + reference model: the key state is the last three
  // accepted samples agreeing on a value different from the old one.
  always @(posedge clk) begin
    cyc++;
    acc = 1'b0;
    if (reset) begin
      hist.delete();
      m_stable = 2'b00;
      m_press  = 2'b00;
      m_rel    = 2'b00;
    end else if (avm.read && !avm.waitrequest) begin
      acc = 1'b1;
      acc_cnt++;
      m_s = ~raw;
      hist.push_back(m_s);
      m_press = 2'b00;
      m_rel   = 2'b00;
      if (hist.size() >= 3 && hist[$] == hist[$-1] &&
          hist[$-1] == hist[$-2] && m_s != m_stable) begin
        m_press  = m_s & ~m_stable;
        m_rel    = ~m_s & m_stable;
        m_stable = m_s;
      end
    end
    rd = $urandom;
    if (acc) rd[1:0] = raw;
    #1 avm.readdata = rd;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read(output bit seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (avm.read) seen = 1'b1;
      else begin
        step();
        n++;
      end
    end
    chk("read_seen", 32'(seen), 32'd1);
  endtask

  task automatic do_poll(input logic [1:0] raw_v, input int ws,
                         input logic [1:0] clr, input bit chk_per);
    bit seen;
    int a0;
    raw = raw_v;
    wait_read(seen);
    if (!seen) return;
    chk("addr", 32'(avm.address), 32'd0);
    if (chk_per && last_rise >= 0)
      chk("poll_period", 32'(cyc - last_rise), 32'd8);
    last_rise = cyc;
    a0 = acc_cnt;
    if (ws > 0) begin
      avm.waitrequest = 1'b1;
      for (int i = 0; i < ws; i++) begin
        step();
        chk("read_hold", 32'({avm.read, avm.address}), 32'h4);
      end
      avm.waitrequest = 1'b0;
    end
    step();
    chk("read_drop", 32'(avm.read), 32'd0);
    chk("one_accept", 32'(acc_cnt - a0), 32'd1);
    step();
    step();
    flag_clr = clr;
    chk("keys_stable", 32'(keys_stable), 32'(m_stable));
    chk("press_pulse", 32'(press_pulse), 32'(m_press));
    chk("release_pulse", 32'(release_pulse), 32'(m_rel));
    m_flags = (m_flags & ~clr) | m_press;
    step();
    flag_clr = 2'b00;
    chk("press_end", 32'(press_pulse), 32'd0);
    chk("release_end", 32'(release_pulse), 32'd0);
    chk("press_flags", 32'(press_flags), 32'(m_flags));
    step();
    chk("irq", 32'(irq), 32'(|m_flags));
  endtask

  task automatic lone_clear(input logic [1:0] clr);
    flag_clr = clr;
    m_flags  = m_flags & ~clr;
    step();
    flag_clr = 2'b00;
    chk("clr_flags", 32'(press_flags), 32'(m_flags));
    step();
    chk("clr_irq", 32'(irq), 32'(|m_flags));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_read"}, 32'(avm.read), 32'd0);
    chk({tag, "_keys"}, 32'(keys_stable), 32'd0);
    chk({tag, "_pulses"}, 32'({press_pulse, release_pulse}), 32'd0);
    chk({tag, "_flags"}, 32'(press_flags), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int n;
    bit seen;
    logic [1:0] rv;
    int reps;
    avm.waitrequest = 1'b0;
    reset = 1'b1;
    step();
    step();
    step();
    chk_zero_outputs("reset");
    reset = 1'b0;
    n = 0;
    while (!avm.read && n < 40) begin
      step();
      n++;
    end
    chk("first_poll", 32'(n), 32'd8);

    for (int i = 0; i < 3; i++) do_poll(2'b11, 0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) do_poll(2'b10, 0, 2'b00, 1'b1);
    chk("press_state", 32'(keys_stable), 32'h1);
    lone_clear(2'b01);

    for (int i = 0; i < 3; i++) do_poll(2'b11, 0, 2'b00, 1'b1);
    chk("released", 32'(keys_stable), 32'h0);
    do_poll(2'b10, 0, 2'b01, 1'b1);
    do_poll(2'b11, 0, 2'b01, 1'b1);
    do_poll(2'b10, 0, 2'b01, 1'b1);
    do_poll(2'b10, 0, 2'b01, 1'b1);
    do_poll(2'b10, 0, 2'b01, 1'b1);
    chk("bounce_state", 32'(keys_stable), 32'h1);
    chk("set_wins", 32'(press_flags), 32'h1);
    chk("no_ovr_yet", 32'(overrun), 32'd0);
    lone_clear(2'b01);

    do_poll(2'b10, 12, 2'b00, 1'b1);
    chk("overrun", 32'(overrun), 32'd1);

    last_rise = -1;
    for (int i = 0; i < 8; i++) begin
      rv   = 2'($urandom_range(0, 3));
      reps = $urandom_range(1, 4);
      for (int j = 0; j < reps; j++)
        do_poll(rv, $urandom_range(0, 2), 2'($urandom_range(0, 3)), 1'b1);
    end
    chk("overrun_sticky", 32'(overrun), 32'd1);

    wait_read(seen);
    avm.waitrequest = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    chk_zero_outputs("midreset");
    m_flags = 2'b00;
    last_rise = -1;
    avm.waitrequest = 1'b0;
    step();
    reset = 1'b0;
    n = 0;
    while (!avm.read && n < 40) begin
      step();
      n++;
    end
    chk("resume", 32'(n), 32'd8);
    for (int i = 0; i < 3; i++) do_poll(2'b01, 0, 2'b00, 1'b1);
    chk("after_reset", 32'(keys_stable), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
